// File: rtl/list_sum_ctrl.sv
// Buffers one list of up to LENGTH elements, hands it to an external summing
// stage, then presents the sum. Optional watchdog: define LIST_SUM_TIMEOUT_EN.
module list_sum_ctrl #(
  parameter  int DATA_WIDTH     = 32,
  parameter  int LENGTH         = 8,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int SUM_WIDTH      = $clog2(LENGTH) + DATA_WIDTH,
  localparam int CNT_WIDTH      = $clog2(LENGTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [LENGTH*DATA_WIDTH-1:0] list_data,
  output logic                         sum_start,
  input  logic                         sum_done,
  input  logic [SUM_WIDTH-1:0]         sum_result,
  output logic                         out_valid,
  output logic [SUM_WIDTH-1:0]         out_sum,
  output logic [CNT_WIDTH-1:0]         out_count,
  output logic                         out_err,
  input  logic                         out_ready
);

  localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  typedef enum logic [1:0] {FILL, SUM, OUT} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] buf_q [LENGTH];
  logic [IDX_W-1:0]      wr_ptr_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [SUM_WIDTH-1:0]  out_sum_q;
  logic [CNT_WIDTH-1:0]  out_count_q;
  logic                  accept;

  if (TIMEOUT_CYCLES < 1 || LENGTH < 1) begin : g_bad_cfg
    $error("list_sum_ctrl: LENGTH and TIMEOUT_CYCLES must be >= 1");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

`ifdef LIST_SUM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q;
  logic             tmo_hit;
  logic             out_err_q;

  // Counter holds at 0 outside SUM, so it restarts on every SUM entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                tmo_q <= '0;
    else if (state_q != SUM) tmo_q <= '0;
    else                    tmo_q <= tmo_q + 1'b1;
  end

  // Fires in the last allowed SUM cycle; a simultaneous sum_done wins.
  assign tmo_hit = (state_q == SUM) && !sum_done &&
                   (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                out_err_q <= 1'b0;
    else if (state_q == SUM && sum_done)    out_err_q <= 1'b0;
    else if (tmo_hit)                       out_err_q <= 1'b1;
  end

  assign out_err = out_err_q;
`else
  assign out_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    sum_start = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && (in_last || count_q == CNT_WIDTH'(LENGTH - 1)))
          state_d = SUM;
      end
      SUM: begin
        sum_start = 1'b1;
        if (sum_done) state_d = OUT;
`ifdef LIST_SUM_TIMEOUT_EN
        else if (tmo_hit) state_d = OUT;
`endif
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LENGTH; k++) buf_q[k] <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_sum_q   <= '0;
      out_count_q <= '0;
    end else begin
      if (accept) begin
        buf_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
        count_q         <= count_q + 1'b1;
      end
      if (state_q == SUM && sum_done) begin
        out_sum_q   <= sum_result;
        out_count_q <= count_q;
      end
`ifdef LIST_SUM_TIMEOUT_EN
      else if (tmo_hit) begin
        out_sum_q   <= '0;
        out_count_q <= count_q;
      end
`endif
      // Clearing on consumption makes unwritten entries of the next list read 0.
      if (state_q == OUT && out_ready) begin
        for (int k = 0; k < LENGTH; k++) buf_q[k] <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end
    end
  end

  for (genvar g = 0; g < LENGTH; g++) begin : g_pack
    assign list_data[g*DATA_WIDTH +: DATA_WIDTH] = buf_q[g];
  end

  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_list_sum_ctrl.sv
// Self-checking bench for list_sum_ctrl: vector table, hand-written corner
// sequences and randomized lists checked against a plain-arithmetic model.
module tb_list_sum_ctrl;

  localparam int DW = 32;
  localparam int L  = 8;
  localparam int SW = 35;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic [L*DW-1:0] list_data;
  logic          sum_start;
  logic          sum_done;
  logic [SW-1:0] sum_result;
  logic          out_valid;
  logic [SW-1:0] out_sum;
  logic [CW-1:0] out_count;
  logic          out_err;
  logic          out_ready;

  int errs;
  int checks;

  list_sum_ctrl #(.DATA_WIDTH(DW), .LENGTH(L), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .list_data(list_data),
    .sum_start(sum_start), .sum_done(sum_done), .sum_result(sum_result),
    .out_valid(out_valid), .out_sum(out_sum), .out_count(out_count),
    .out_err(out_err), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]         n;
    logic [L-1:0][31:0] v;
    logic               use_last;
    logic [3:0]         dly;
    logic [3:0]         hold;
    logic [SW-1:0]      exp_sum;
    logic [3:0]         exp_cnt;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SW-1:0] model_sum(input int n, input logic [L-1:0][31:0] v);
    longint s = 0;
    for (int k = 0; k < n; k++) s += longint'(v[k]);
    return s[SW-1:0];
  endfunction

  task automatic send_beats(input int n, input logic [L-1:0][31:0] v, input bit use_last);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = v[i];
      in_last  = use_last && (i == n - 1);
      chk("in_ready_fill", in_ready, 1);
      tick();
      if (i < n - 1) chk("no_start_mid", sum_start, 0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Stub summing stage plus result check and output handshake.
  task automatic finish(input int n, input logic [L-1:0][31:0] v, input int dly,
                        input int hold, input logic [SW-1:0] exp_sum, input int exp_cnt);
    logic [SW-1:0] stub;
    chk("start_latency", sum_start, 1);
    chk("in_ready_sum", in_ready, 0);
    chk("out_valid_sum", out_valid, 0);
    for (int k = 0; k < L; k++)
      chk("list_entry", list_data[k*DW +: DW], (k < n) ? v[k] : 32'd0);
    stub = '0;
    for (int k = 0; k < L; k++) stub += SW'(list_data[k*DW +: DW]);
    for (int d = 0; d < dly; d++) begin
      tick();
      chk("start_held", sum_start, 1);
    end
    sum_done   = 1'b1;
    sum_result = stub;
    tick();
    sum_done   = 1'b0;
    sum_result = SW'($urandom);
    chk("out_valid", out_valid, 1);
    chk("start_drop", sum_start, 0);
    chk("in_ready_out", in_ready, 0);
    chk("out_sum", out_sum, exp_sum);
    chk("out_count", out_count, exp_cnt);
    chk("out_err", out_err, 0);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", out_sum, exp_sum);
      chk("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_ready", in_ready, 1);
    chk("post_clear", (list_data == '0), 1);
  endtask

  initial begin
    vec_t tbl [6];
    logic [L-1:0][31:0] v;
    logic [SW-1:0] prev;
    errs = 0; checks = 0;
    in_valid = 0; in_data = '0; in_last = 0;
    sum_done = 0; sum_result = '0; out_ready = 0;

    tbl[0] = '{n: 8, v: '0, use_last: 1, dly: 3, hold: 0, exp_sum: 35'd36, exp_cnt: 8};
    for (int k = 0; k < L; k++) tbl[0].v[k] = 32'(k + 1);
    tbl[1] = '{n: 3, v: '0, use_last: 1, dly: 0, hold: 0, exp_sum: 35'd18, exp_cnt: 3};
    tbl[1].v[0] = 5; tbl[1].v[1] = 6; tbl[1].v[2] = 7;
    tbl[2] = '{n: 1, v: '0, use_last: 1, dly: 1, hold: 5, exp_sum: 35'd42, exp_cnt: 1};
    tbl[2].v[0] = 42;
    tbl[3] = '{n: 8, v: '1, use_last: 1, dly: 2, hold: 1, exp_sum: 35'h7_FFFF_FFF8, exp_cnt: 8};
    tbl[4] = '{n: 8, v: '0, use_last: 0, dly: 0, hold: 2, exp_sum: 35'd800, exp_cnt: 8};
    for (int k = 0; k < L; k++) tbl[4].v[k] = 32'(100);
    tbl[5] = '{n: 2, v: '0, use_last: 1, dly: 4, hold: 0, exp_sum: 35'h1_0000_0000, exp_cnt: 2};
    tbl[5].v[0] = 32'hFFFF_FFFF; tbl[5].v[1] = 1;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_start", sum_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_list", (list_data == '0), 1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      send_beats(int'(tbl[i].n), tbl[i].v, tbl[i].use_last);
      finish(int'(tbl[i].n), tbl[i].v, int'(tbl[i].dly), int'(tbl[i].hold),
             tbl[i].exp_sum, int'(tbl[i].exp_cnt));
    end

    // sum_done outside SUM has no effect
    prev = out_sum;
    sum_done = 1'b1; sum_result = 35'd123;
    tick();
    sum_done = 1'b0;
    chk("done_ignored_valid", out_valid, 0);
    chk("done_ignored_sum", out_sum, prev);

    // Overflow beat waits in SUM/OUT and becomes element 0 of the next list
    for (int k = 0; k < L; k++) v[k] = 32'(11 + k);
    send_beats(8, v, 1'b0);
    in_valid = 1'b1; in_data = 32'd99; in_last = 1'b1;
    chk("ninth_blocked", in_ready, 0);
    finish(8, v, 2, 1, 35'd116, 8);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    v = '0; v[0] = 32'd99;
    finish(1, v, 0, 0, 35'd99, 1);

    // Reset two cycles into SUM discards the list
    v = '0; v[0] = 3; v[1] = 4;
    send_beats(2, v, 1'b1);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rst_sum_start", sum_start, 0);
    chk("rst_sum_in_ready", in_ready, 1);
    chk("rst_sum_list", (list_data == '0), 1);
    tick();
    rst = 1'b0;
    v = '0; v[0] = 10; v[1] = 20;
    send_beats(2, v, 1'b1);
    finish(2, v, 1, 0, 35'd30, 2);

    // Reset while presenting a result
    v = '0; v[0] = 77;
    send_beats(1, v, 1'b1);
    sum_done = 1'b1; sum_result = 35'd77;
    tick();
    sum_done = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst_out_drop", out_valid, 0);
    chk("rst_out_sum_clr", out_sum, 0);
    chk("rst_out_cnt_clr", out_count, 0);
    tick();
    rst = 1'b0;
    chk("rst_out_ready", in_ready, 1);

    // Randomized lists against the model
    for (int r = 0; r < 20; r++) begin
      int n;
      bit ul;
      n = $urandom_range(1, L);
      v = '0;
      for (int k = 0; k < n; k++)
        v[k] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      ul = (n < L) ? 1'b1 : 1'($urandom_range(0, 1));
      send_beats(n, v, ul);
      finish(n, v, $urandom_range(0, 4), $urandom_range(0, 3), model_sum(n, v), n);
    end

`ifdef LIST_SUM_TIMEOUT_EN
    begin
      int cyc;
      v = '0; v[0] = 1; v[1] = 2; v[2] = 3;
      send_beats(3, v, 1'b1);
      cyc = 0;
      while (!out_valid && cyc < 200) begin
        tick();
        cyc++;
      end
      chk("tmo_cycles", cyc, 64);
      chk("tmo_err", out_err, 1);
      chk("tmo_sum", out_sum, 0);
      chk("tmo_count", out_count, 3);
      chk("tmo_start", sum_start, 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("tmo_post_ready", in_ready, 1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
